edge_pixel_writer: RTL
======================

Name: edge_pixel_writer

Overview:
Downstream stage of the edge-detection core. It consumes the 8-bit processed-pixel stream (pixel + valid, no backpressure) and packs four pixels per 32-bit word into a small word FIFO. It writes the words to a frame buffer through an Avalon-MM write master. It reports busy, done and a sticky overflow flag to the system controller.

Parameters:
IMG_X_SIZE, 100, image width in pixels
IMG_Y_SIZE, 100, image height in pixels; N = IMG_X_SIZE*IMG_Y_SIZE pixels per frame
FIFO_DEPTH, 8, word FIFO entries (power of 2, >=2)

Ports:
clk_i  in  1  system clock, all logic on rising edge
rst_i  in  1  asynchronous, active-low reset
start_i  in  1  one-cycle frame start request
base_addr_i  in  32  frame buffer byte address, word aligned, sampled on accepted start
pixel_i  in  8  processed pixel from the edge core
pixel_valid_i  in  1  pixel_i valid this cycle
avm_address_o  out  32  Avalon byte address
avm_write_o  out  1  Avalon write request
avm_writedata_o  out  32  packed pixels, lane k = bits 8k+7:8k
avm_byteenable_o  out  4  valid byte lanes
avm_waitrequest_i  in  1  slave stall
busy_o  out  1  frame in progress
done_o  out  1  one-cycle pulse at frame completion
overflow_o  out  1  sticky: at least one word dropped this frame

Behaviour:
- Reset (rst_i=0, any time, async): every output 0. FSM goes to IDLE. FIFO is emptied, counters and packer are cleared. An in-flight write is abandoned.
- FSM states are IDLE, RUN and DRAIN.
- IDLE:
  - start_i=1: latch base_addr_i, clear pixel count, word index, packer and overflow_o, then go to RUN. busy_o=1 from the next cycle.
  - pixel_valid_i is ignored.
- RUN/DRAIN: start_i is ignored.
- Packing:
  - Each pixel_valid_i in RUN writes pixel_i into byte lane pix_cnt[1:0] of the packing register, sets the matching byteenable bit, and increments pix_cnt.
  - A word is pushed when lane 3 is written, or when the N-th pixel is written. A partial last word has unused lanes 0 and their byteenable bits 0.
  - Each entry holds {address = base + 4*word_idx, data, byteenable}. word_idx increments on every push attempt, including dropped ones, so later words keep correct addresses.
- RUN -> DRAIN on the cycle the N-th pixel is accepted. Pixels arriving in DRAIN are ignored.
- FIFO:
  - A push when full with no pop in the same cycle drops the word and sets overflow_o. overflow_o stays 1 until the next accepted start.
  - A push and pop in the same cycle when full is accepted, no drop.
- Write master:
  - When the FIFO is not empty, drive the head entry with avm_write_o=1.
  - Address, data and byteenable are held stable while avm_waitrequest_i=1.
  - Pop on avm_write_o & !avm_waitrequest_i.
  - avm_write_o is 0 when the FIFO is empty.
- Latency: word pushed at clock edge t -> avm_write_o=1 in the cycle after t (if the FIFO was empty). Back-to-back writes are possible at 1 word/cycle.
- DRAIN -> IDLE when the FIFO is empty and no write is pending. done_o=1 for exactly that one cycle. busy_o=0 from the same cycle.
- Arithmetic: pix_cnt is $clog2(N+1) bits. Address is 32-bit unsigned and wraps modulo 2^32.

Test Plan:
1. IMG 3x3, base 0x1000, waitrequest=0, pixels 0x01..0x09 on consecutive cycles -> three writes:
   - 0x1000 / 0x04030201 / be F
   - 0x1004 / 0x08070605 / be F
   - 0x1008 / 0x00000009 / be 1
   done_o pulses once the cycle after the last accepted write; overflow_o=0.
2. Scenario 1 with waitrequest=1 for 5 cycles on the first write -> address, data and be stable all 5 cycles; all 3 writes complete in order; no overflow.
3. IMG 4x4, FIFO_DEPTH 2, waitrequest=1 during all 16 pixel cycles, then 0 ->
   - overflow_o=1
   - exactly two writes: base+0, base+4
   - done_o pulses; next start clears overflow_o
4. start_i pulsed in RUN, and pixel_valid_i pulsed in IDLE and DRAIN -> no effect: write count, addresses and data unchanged vs scenario 1.
5. rst_i low for 1 cycle mid-DRAIN with a write stalled -> all outputs 0 immediately; then start with base 0x2000 reruns scenario 1 correctly at 0x2000..0x2008.
6. IMG 2x3 (N=6), pixels 0xA0..0xA5 -> writes 0xA3A2A1A0 be F, then 0x0000A5A4 be 3.

Source files
------------

// File: rtl/edge_pixel_writer.sv
// Packs the processed 8-bit pixel stream four pixels per 32-bit word, queues
// the words in a small FIFO and writes them to the frame buffer through an
// Avalon-MM write master. Reports busy, done and a sticky overflow flag.
module edge_pixel_writer #(
  parameter int IMG_X_SIZE = 100,
  parameter int IMG_Y_SIZE = 100,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] base_addr_i,
  input  logic [7:0]  pixel_i,
  input  logic        pixel_valid_i,
  output logic [31:0] avm_address_o,
  output logic        avm_write_o,
  output logic [31:0] avm_writedata_o,
  output logic [3:0]  avm_byteenable_o,
  input  logic        avm_waitrequest_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        overflow_o
);

  localparam int N  = IMG_X_SIZE * IMG_Y_SIZE;
  localparam int CW = $clog2(N + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST_PIX = CW'(N - 1);
  localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [31:0]   base_q;
  logic [CW-1:0] pix_cnt_q;
  logic [CW-1:0] word_idx_q;
  logic [31:0]   pack_data_q;
  logic [3:0]    pack_be_q;
  logic          overflow_q;

  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic [31:0]   mem_addr_q [FIFO_DEPTH];
  logic [31:0]   mem_data_q [FIFO_DEPTH];
  logic [3:0]    mem_be_q   [FIFO_DEPTH];

  logic        pix_accept, last_pix, push, push_ok, pop, drop;
  logic        fifo_empty, fifo_full, start_ok;
  logic [1:0]  lane;
  logic [31:0] merged_data, push_addr;
  logic [3:0]  merged_be;

  assign start_ok   = (state_q == IDLE) && start_i;
  assign pix_accept = (state_q == RUN) && pixel_valid_i;
  assign lane       = pix_cnt_q[1:0];
  assign last_pix   = (pix_cnt_q == LAST_PIX);
  // A word leaves the packer when lane 3 fills or the frame's last pixel lands.
  assign push       = pix_accept && ((lane == 2'd3) || last_pix);
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == DEPTH_C);
  assign pop        = !fifo_empty && !avm_waitrequest_i;
  // A full FIFO still takes the word if the head leaves in the same cycle.
  assign push_ok    = push && (!fifo_full || pop);
  assign drop       = push && fifo_full && !pop;
  assign push_addr  = base_q + (32'(word_idx_q) << 2);

  // Packing register contents including the pixel arriving this cycle.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign merged_data[8*gi +: 8] = (lane == 2'(gi)) ? pixel_i : pack_data_q[8*gi +: 8];
    assign merged_be[gi]          = pack_be_q[gi] | (lane == 2'(gi));
  end

  // Next-state and status decode; done is the single DRAIN cycle with an empty FIFO.
  always_comb begin
    state_d = state_q;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    unique case (state_q)
      IDLE: if (start_i) state_d = RUN;
      RUN: begin
        busy_o = 1'b1;
        if (pix_accept && last_pix) state_d = DRAIN;
      end
      DRAIN: begin
        if (fifo_empty) begin
          done_o  = 1'b1;
          state_d = IDLE;
        end else begin
          busy_o = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Frame bookkeeping and packer; word_idx advances even for dropped words.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      base_q      <= '0;
      pix_cnt_q   <= '0;
      word_idx_q  <= '0;
      pack_data_q <= '0;
      pack_be_q   <= '0;
      overflow_q  <= 1'b0;
    end else begin
      if (start_ok) begin
        base_q      <= base_addr_i;
        pix_cnt_q   <= '0;
        word_idx_q  <= '0;
        pack_data_q <= '0;
        pack_be_q   <= '0;
        overflow_q  <= 1'b0;
      end else if (pix_accept) begin
        pix_cnt_q <= pix_cnt_q + 1'b1;
        if (push) begin
          pack_data_q <= '0;
          pack_be_q   <= '0;
          word_idx_q  <= word_idx_q + 1'b1;
        end else begin
          pack_data_q <= merged_data;
          pack_be_q   <= merged_be;
        end
      end
      if (drop) overflow_q <= 1'b1;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_ok && !pop)      count_q <= count_q + 1'b1;
      else if (!push_ok && pop) count_q <= count_q - 1'b1;
    end
  end

  // FIFO storage; contents are meaningless while the slot is not occupied.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_addr_q[wr_ptr_q] <= push_addr;
      mem_data_q[wr_ptr_q] <= merged_data;
      mem_be_q[wr_ptr_q]   <= merged_be;
    end
  end

  // Head entry drives the bus; held while the slave stalls, zero when idle.
  assign avm_write_o      = !fifo_empty;
  assign avm_address_o    = fifo_empty ? 32'h0 : mem_addr_q[rd_ptr_q];
  assign avm_writedata_o  = fifo_empty ? 32'h0 : mem_data_q[rd_ptr_q];
  assign avm_byteenable_o = fifo_empty ? 4'h0  : mem_be_q[rd_ptr_q];
  assign overflow_o       = overflow_q;

endmodule
